// File: rtl/uart_tx_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// uart_tx_burst_ctrl_if
// ----------------------------------------------------------------------------
// Bundles the register-side, buffer-write and TX-core handshake signals of
// the UART burst transmit sequencer.
//
// Signals:
//   send_i, len_i, gap_i, abort_i       control-register side requests
//   wr_en_i, wr_addr_i, wr_data_i       burst buffer write port
//   tx_done_i / tx_start_o, tx_data_o   TX shift-core handshake
//   we_reg_control_o, sel_control_o     control-register write-back (clear send)
//   busy_o, done_o, aborted_o, idx_o    status
// Modports:
//   slave  - the sequencer (drives the *_o signals)
//   master - register block / TX core / bench (drives the *_i signals)
// Revision: 1.0 - initial release
// ============================================================================
interface uart_tx_burst_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int GAP_W  = 17
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic              send_i;
  logic [LW-1:0]     len_i;
  logic [GAP_W-1:0]  gap_i;
  logic              abort_i;
  logic              wr_en_i;
  logic [AW-1:0]     wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              tx_done_i;
  logic              tx_start_o;
  logic [DATA_W-1:0] tx_data_o;
  logic              we_reg_control_o;
  logic              sel_control_o;
  logic              busy_o;
  logic              done_o;
  logic              aborted_o;
  logic [LW-1:0]     idx_o;

  modport slave (
    input  send_i, len_i, gap_i, abort_i, wr_en_i, wr_addr_i, wr_data_i, tx_done_i,
    output tx_start_o, tx_data_o, we_reg_control_o, sel_control_o,
           busy_o, done_o, aborted_o, idx_o
  );

  modport master (
    output send_i, len_i, gap_i, abort_i, wr_en_i, wr_addr_i, wr_data_i, tx_done_i,
    input  tx_start_o, tx_data_o, we_reg_control_o, sel_control_o,
           busy_o, done_o, aborted_o, idx_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_burst_ctrl.sv
`default_nettype none
// ============================================================================
// uart_tx_burst_ctrl
// ----------------------------------------------------------------------------
// Sends a burst of 1..DEPTH bytes from an internal buffer through the UART TX
// core, with a programmable idle gap between frames and abort support. At the
// end of each burst the send bit is cleared through the control-register
// write-back mux.
//
// Ports:
//   clk_i  - system clock
//   rst_i  - asynchronous active-low reset
//   bus    - uart_tx_burst_ctrl_if.slave (register, buffer and TX-core signals)
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_burst_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int GAP_W  = 17
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  uart_tx_burst_ctrl_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    GAP   = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t            state, next_state;
  logic [LW-1:0]     len_q;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  cnt;
  logic [LW-1:0]     idx;
  logic              abort_pend;
  logic              aborted;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              abort_any;
  logic              abort_exit;   // leaving to STOP because of an abort
  logic              start_pulse;
  logic [LW-1:0]     idx_inc;
  logic [LW-1:0]     len_sat;

  assign abort_any = abort_pend | bus.abort_i;
  assign idx_inc   = idx + LW'(1);
  assign len_sat   = (bus.len_i > DEPTH_L) ? DEPTH_L : bus.len_i;

  // Buffer: no reset; the LOAD read below sees the pre-edge contents, so a
  // same-cycle write to the address being loaded returns the old byte.
  always_ff @(posedge clk_i) begin
    if (bus.wr_en_i) mem[bus.wr_addr_i] <= bus.wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    start_pulse = 1'b0;
    abort_exit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.send_i) next_state = (bus.len_i != '0) ? LOAD : STOP;
      end
      LOAD: begin
        if (abort_any) begin
          next_state = STOP;
          abort_exit = 1'b1;
        end else begin
          next_state = START;
        end
      end
      START: begin
        // An abort here suppresses the start pulse entirely.
        if (abort_any) begin
          next_state = STOP;
          abort_exit = 1'b1;
        end else begin
          start_pulse = 1'b1;
          next_state  = DATA;
        end
      end
      DATA: begin
        // A frame in flight always completes; abort is acted on at tx_done.
        if (bus.tx_done_i) begin
          if (abort_any) begin
            next_state = STOP;
            abort_exit = 1'b1;
          end else if (idx_inc == len_q) begin
            next_state = STOP;
          end else if (gap_q == '0) begin
            next_state = LOAD;
          end else begin
            next_state = GAP;
          end
        end
      end
      GAP: begin
        if (abort_any) begin
          next_state = STOP;
          abort_exit = 1'b1;
        end else if (cnt <= GAP_W'(1)) begin
          next_state = LOAD;
        end
      end
      STOP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      len_q      <= '0;
      gap_q      <= '0;
      cnt        <= '0;
      idx        <= '0;
      abort_pend <= 1'b0;
      aborted    <= 1'b0;
      tx_data    <= '0;
    end else begin
      // Abort requests are only remembered while a burst is running; any
      // leftover request dies with the burst so it cannot hit the next one.
      if (abort_exit) begin
        abort_pend <= 1'b0;
        aborted    <= 1'b1;
      end else if (state == STOP) begin
        abort_pend <= 1'b0;
      end else if ((state != IDLE) && bus.abort_i) begin
        abort_pend <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (bus.send_i) begin
            idx     <= '0;
            aborted <= 1'b0;
            if (bus.len_i != '0) begin
              len_q <= len_sat;
              gap_q <= bus.gap_i;
            end
          end
        end
        LOAD: tx_data <= mem[idx[AW-1:0]];
        DATA: begin
          if (bus.tx_done_i) begin
            idx <= idx_inc;
            if (next_state == GAP) cnt <= gap_q;
          end
        end
        GAP: begin
          if (cnt != '0) cnt <= cnt - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_start_o       = start_pulse;
  assign bus.tx_data_o        = tx_data;
  assign bus.we_reg_control_o = (state == STOP);
  assign bus.sel_control_o    = (state == STOP);
  assign bus.done_o           = (state == STOP);
  assign bus.busy_o           = (state != IDLE);
  assign bus.aborted_o        = aborted;
  assign bus.idx_o            = idx;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_burst_ctrl.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_burst_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for uart_tx_burst_ctrl. Models the control register
// (send bit set by software, cleared by the write-back) and the TX core
// (tx_done a fixed number of cycles after tx_start), keeps a shadow copy of
// the buffer, and predicts frame order, data and timing arithmetically.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_burst_ctrl;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int GAP_W  = 17;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = $clog2(DEPTH + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_burst_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .GAP_W(GAP_W)) bus ();

  uart_tx_burst_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  // Control register model: software sets send, write-back clears it.
  logic ctrl_send = 1'b0;
  logic sw_set    = 1'b0;
  logic sw_clr    = 1'b0;
  always @(posedge clk) begin
    if (sw_clr) ctrl_send <= 1'b0;
    else if (bus.we_reg_control_o && bus.sel_control_o) ctrl_send <= 1'b0;
    else if (sw_set) ctrl_send <= 1'b1;
  end
  assign bus.send_i = ctrl_send | sw_set;

  // TX core model: done pulse frame_cycles after each start.
  int   frame_cycles = 4;
  int   core_cnt = 0;
  logic core_done = 1'b0;
  int   td_cyc[$];
  always @(negedge clk) begin
    if (!rst_n) begin
      core_cnt  = 0;
      core_done = 1'b0;
    end else begin
      core_done = 1'b0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_done = 1'b1;
          td_cyc.push_back(cyc);
        end
      end
      if (bus.tx_start_o) core_cnt = frame_cycles;
    end
  end
  assign bus.tx_done_i = core_done;

  // Event recorder.
  int               st_cyc[$];
  logic [DATA_W-1:0] st_dat[$];
  int               dn_cyc[$];
  int               dn_idx[$];
  logic             dn_ab[$];
  logic             dn_ws[$];
  int               we_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_start_o) begin
        st_cyc.push_back(cyc);
        st_dat.push_back(bus.tx_data_o);
      end
      if (bus.done_o) begin
        dn_cyc.push_back(cyc);
        dn_idx.push_back(int'(bus.idx_o));
        dn_ab.push_back(bus.aborted_o);
        dn_ws.push_back(bus.we_reg_control_o & bus.sel_control_o);
      end
      if (bus.we_reg_control_o) we_cnt++;
    end
  end

  logic [DATA_W-1:0] shadow [DEPTH];

  task automatic write_buf(input int a, input int d);
    @(negedge clk);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = AW'(a);
    bus.wr_data_i = DATA_W'(d);
    @(negedge clk);
    bus.wr_en_i   = 1'b0;
    shadow[a]     = DATA_W'(d);
  endtask

  // send becomes visible at cycle c0; first start is expected at c0+2.
  task automatic start_burst(input int len, input int gap, output int c0);
    @(negedge clk);
    bus.len_i = LW'(len);
    bus.gap_i = GAP_W'(gap);
    sw_set    = 1'b1;
    c0        = cyc;
    @(negedge clk);
    sw_set    = 1'b0;
  endtask

  task automatic wait_dn(input int base, input int budget, output bit ok);
    for (int i = 0; i < budget && dn_cyc.size() <= base; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    ok = (dn_cyc.size() > base);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    checks++;
    if (bus.tx_start_o !== 1'b0 || bus.tx_data_o !== '0) begin
      errors++; $display("FAIL reset_tx: start %b data %h want 0 00", bus.tx_start_o, bus.tx_data_o);
    end
    checks++;
    if ({bus.done_o, bus.we_reg_control_o, bus.sel_control_o} !== 3'b000) begin
      errors++; $display("FAIL reset_stop_outs: got %b want 000", {bus.done_o, bus.we_reg_control_o, bus.sel_control_o});
    end
    checks++;
    if (bus.aborted_o !== 1'b0 || bus.idx_o !== '0) begin
      errors++; $display("FAIL reset_status: aborted %b idx %0d want 0 0", bus.aborted_o, bus.idx_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int c0, sb, db, tb0; bit ok;
    frame_cycles = 3;
    write_buf(0, 8'hA5);
    sb = st_cyc.size(); db = dn_cyc.size(); tb0 = td_cyc.size();
    start_burst(1, 0, c0);
    wait_dn(db, 200, ok);
    checks++;
    if (!ok || st_cyc.size() - sb != 1) begin
      errors++; $display("FAIL single_count: starts %0d done_seen %0d want 1 1", st_cyc.size() - sb, ok);
    end else begin
      checks++;
      if (st_cyc[sb] != c0 + 2) begin errors++; $display("FAIL single_start_lat: cyc %0d want %0d", st_cyc[sb], c0 + 2); end
      checks++;
      if (st_dat[sb] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", st_dat[sb]); end
      checks++;
      if (dn_cyc[db] != td_cyc[tb0] + 1 || dn_ws[db] !== 1'b1 || dn_idx[db] != 1) begin
        errors++; $display("FAIL single_stop: cyc %0d we_sel %b idx %0d want %0d 1 1", dn_cyc[db], dn_ws[db], dn_idx[db], td_cyc[tb0] + 1);
      end
    end
    checks++;
    if (bus.busy_o !== 1'b0 || ctrl_send !== 1'b0 || dn_cyc.size() - db != 1) begin
      errors++; $display("FAIL single_idle: busy %b send %b dones %0d want 0 0 1", bus.busy_o, ctrl_send, dn_cyc.size() - db);
    end
  endtask

  task automatic test_gap_burst();
    int c0, sb, db, tb0; bit ok, ok_t, ok_d;
    frame_cycles = 5;
    write_buf(0, 8'h11); write_buf(1, 8'h22); write_buf(2, 8'h33);
    sb = st_cyc.size(); db = dn_cyc.size(); tb0 = td_cyc.size();
    start_burst(3, 4, c0);
    wait_dn(db, 300, ok);
    checks++;
    if (!ok || st_cyc.size() - sb != 3 || td_cyc.size() - tb0 != 3) begin
      errors++; $display("FAIL gap_count: starts %0d done_seen %0d want 3 1", st_cyc.size() - sb, ok);
    end else begin
      ok_t = (st_cyc[sb] == c0 + 2);
      ok_d = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (k > 0 && st_cyc[sb + k] - td_cyc[tb0 + k - 1] != 6) ok_t = 1'b0;
        if (st_dat[sb + k] !== shadow[k]) ok_d = 1'b0;
      end
      checks++;
      if (!ok_t) begin errors++; $display("FAIL gap_timing: starts %0d %0d %0d dones %0d %0d", st_cyc[sb], st_cyc[sb+1], st_cyc[sb+2], td_cyc[tb0], td_cyc[tb0+1]); end
      checks++;
      if (!ok_d) begin errors++; $display("FAIL gap_data: got %h %h %h want 11 22 33", st_dat[sb], st_dat[sb+1], st_dat[sb+2]); end
      checks++;
      if (dn_cyc.size() - db != 1 || dn_idx[db] != 3 || dn_cyc[db] != td_cyc[tb0 + 2] + 1) begin
        errors++; $display("FAIL gap_done: dones %0d idx %0d cyc %0d want 1 3 %0d", dn_cyc.size() - db, dn_idx[db], dn_cyc[db], td_cyc[tb0 + 2] + 1);
      end
    end
  endtask

  task automatic test_zero_len();
    int c0, sb, db; bit ok;
    sb = st_cyc.size(); db = dn_cyc.size();
    start_burst(0, 7, c0);
    wait_dn(db, 50, ok);
    checks++;
    if (!ok || dn_cyc[db] != c0 + 1 || dn_idx[db] != 0 || dn_ws[db] !== 1'b1 || st_cyc.size() != sb) begin
      errors++; $display("FAIL zero_len: done_seen %0d cyc %0d idx %0d we_sel %b starts %0d want 1 %0d 0 1 0",
                         ok, dn_cyc[db], dn_idx[db], dn_ws[db], st_cyc.size() - sb, c0 + 1);
    end
  endtask

  task automatic test_abort();
    int c0, a0, sb, db, tb0; bit ok;
    frame_cycles = 5;
    for (int a = 0; a < 4; a++) write_buf(a, 8'h40 + a);
    // Abort while waiting out a long gap.
    sb = st_cyc.size(); db = dn_cyc.size(); tb0 = td_cyc.size();
    start_burst(4, 100, c0);
    for (int i = 0; i < 100 && td_cyc.size() <= tb0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    bus.abort_i = 1'b1; a0 = cyc;
    @(negedge clk);
    bus.abort_i = 1'b0;
    wait_dn(db, 300, ok);
    checks++;
    if (!ok || dn_cyc[db] != a0 + 1 || dn_ab[db] !== 1'b1 || dn_idx[db] != 1 || st_cyc.size() - sb != 1) begin
      errors++; $display("FAIL abort_gap: seen %0d cyc %0d aborted %b idx %0d starts %0d want 1 %0d 1 1 1",
                         ok, dn_cyc[db], dn_ab[db], dn_idx[db], st_cyc.size() - sb, a0 + 1);
    end
    // Abort while a frame is in flight: STOP follows tx_done.
    frame_cycles = 6;
    sb = st_cyc.size(); db = dn_cyc.size(); tb0 = td_cyc.size();
    start_burst(3, 0, c0);
    for (int i = 0; i < 20 && st_cyc.size() <= sb; i++) @(negedge clk);
    @(negedge clk);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    wait_dn(db, 300, ok);
    checks++;
    if (!ok || td_cyc.size() - tb0 != 1 || dn_cyc[db] != td_cyc[tb0] + 1 || dn_ab[db] !== 1'b1 ||
        dn_idx[db] != 1 || st_cyc.size() - sb != 1) begin
      errors++; $display("FAIL abort_data: seen %0d cyc %0d aborted %b idx %0d starts %0d want 1 %0d 1 1 1",
                         ok, dn_cyc[db], dn_ab[db], dn_idx[db], st_cyc.size() - sb, td_cyc[tb0] + 1);
    end
  endtask

  task automatic test_live_write();
    int c0, sb, db; bit ok;
    frame_cycles = 6;
    write_buf(0, 8'h01); write_buf(1, 8'h02);
    sb = st_cyc.size(); db = dn_cyc.size();
    start_burst(2, 0, c0);
    for (int i = 0; i < 20 && st_cyc.size() <= sb; i++) @(negedge clk);
    write_buf(1, 8'h5A);
    wait_dn(db, 200, ok);
    checks++;
    if (!ok || st_cyc.size() - sb != 2 || st_dat[sb] !== 8'h01 || st_dat[sb + 1] !== 8'h5A) begin
      errors++; $display("FAIL live_write: starts %0d data %h %h want 2 01 5a", st_cyc.size() - sb, st_dat[sb], st_dat[sb + 1]);
    end
    // Write to buf[0] in the very cycle LOAD reads it: old byte goes out.
    write_buf(0, 8'hC3);
    frame_cycles = 2;
    sb = st_cyc.size(); db = dn_cyc.size();
    @(negedge clk);
    bus.len_i = LW'(1); bus.gap_i = '0; sw_set = 1'b1; c0 = cyc;
    @(negedge clk);
    sw_set = 1'b0;
    bus.wr_en_i = 1'b1; bus.wr_addr_i = '0; bus.wr_data_i = 8'h3C;
    @(negedge clk);
    bus.wr_en_i = 1'b0; shadow[0] = 8'h3C;
    wait_dn(db, 100, ok);
    checks++;
    if (!ok || st_cyc.size() - sb != 1 || st_dat[sb] !== 8'hC3) begin
      errors++; $display("FAIL rbw_old: starts %0d data %h want 1 c3", st_cyc.size() - sb, st_dat[sb]);
    end
    sb = st_cyc.size(); db = dn_cyc.size();
    start_burst(1, 0, c0);
    wait_dn(db, 100, ok);
    checks++;
    if (!ok || st_cyc.size() - sb != 1 || st_dat[sb] !== 8'h3C) begin
      errors++; $display("FAIL rbw_new: starts %0d data %h want 1 3c", st_cyc.size() - sb, st_dat[sb]);
    end
  endtask

  task automatic test_random();
    int c0, sb, db, tb0, len, gap, n, exp_c; bit ok, ok_t, ok_d;
    for (int b = 0; b < 6; b++) begin
      frame_cycles = $urandom_range(1, 4);
      for (int a = 0; a < DEPTH; a++) write_buf(a, $urandom_range(0, 255));
      len = $urandom_range(1, DEPTH + 3);
      gap = $urandom_range(0, 5);
      n   = (len > DEPTH) ? DEPTH : len;
      @(negedge clk); bus.abort_i = 1'b1;   // ignored in IDLE
      @(negedge clk); bus.abort_i = 1'b0;
      sb = st_cyc.size(); db = dn_cyc.size(); tb0 = td_cyc.size();
      start_burst(len, gap, c0);
      bus.len_i = LW'($urandom_range(0, 31));       // ignored while busy
      bus.gap_i = GAP_W'($urandom_range(0, 50));
      wait_dn(db, 3000, ok);
      checks++;
      if (!ok || st_cyc.size() - sb != n || td_cyc.size() - tb0 != n) begin
        errors++; $display("FAIL rand%0d_count: starts %0d done_seen %0d want %0d 1", b, st_cyc.size() - sb, ok, n);
      end else begin
        ok_t = 1'b1; ok_d = 1'b1; exp_c = c0 + 2;
        for (int k = 0; k < n; k++) begin
          if (st_cyc[sb + k] != exp_c) ok_t = 1'b0;
          if (st_dat[sb + k] !== shadow[k]) ok_d = 1'b0;
          exp_c = td_cyc[tb0 + k] + gap + 2;
        end
        checks++;
        if (!ok_t) begin errors++; $display("FAIL rand%0d_timing: len %0d gap %0d first start %0d want %0d", b, len, gap, st_cyc[sb], c0 + 2); end
        checks++;
        if (!ok_d) begin errors++; $display("FAIL rand%0d_data: first %h want %h", b, st_dat[sb], shadow[0]); end
        checks++;
        if (dn_cyc.size() - db != 1 || dn_cyc[db] != td_cyc[tb0 + n - 1] + 1 || dn_idx[db] != n || dn_ab[db] !== 1'b0) begin
          errors++; $display("FAIL rand%0d_done: dones %0d cyc %0d idx %0d aborted %b want 1 %0d %0d 0",
                             b, dn_cyc.size() - db, dn_cyc[db], dn_idx[db], dn_ab[db], td_cyc[tb0 + n - 1] + 1, n);
        end
      end
    end
    checks++;
    if (we_cnt != dn_cyc.size()) begin errors++; $display("FAIL we_done_match: we %0d done %0d", we_cnt, dn_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    int c0, sb, db; bit ok;
    frame_cycles = 20;
    write_buf(0, 8'h77); write_buf(1, 8'h78);
    sb = st_cyc.size();
    start_burst(2, 0, c0);
    for (int i = 0; i < 20 && st_cyc.size() <= sb; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.tx_data_o !== '0 || bus.idx_o !== '0 || bus.tx_start_o !== 1'b0 ||
        {bus.done_o, bus.we_reg_control_o, bus.sel_control_o} !== 3'b000 || bus.aborted_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid: busy %b data %h idx %0d start %b want 0 00 0 0", bus.busy_o, bus.tx_data_o, bus.idx_o, bus.tx_start_o);
    end
    @(negedge clk); sw_clr = 1'b1;
    @(negedge clk); sw_clr = 1'b0; rst_n = 1'b1;
    frame_cycles = 3;
    write_buf(0, 8'h6E);
    sb = st_cyc.size(); db = dn_cyc.size();
    start_burst(1, 0, c0);
    wait_dn(db, 100, ok);
    checks++;
    if (!ok || st_cyc.size() - sb != 1 || st_cyc[sb] != c0 + 2 || st_dat[sb] !== 8'h6E || dn_idx[db] != 1) begin
      errors++; $display("FAIL reset_recover: starts %0d cyc %0d data %h idx %0d want 1 %0d 6e 1",
                         st_cyc.size() - sb, st_cyc[sb], st_dat[sb], dn_idx[db], c0 + 2);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.len_i     = '0;
    bus.gap_i     = '0;
    bus.abort_i   = 1'b0;
    bus.wr_en_i   = 1'b0;
    bus.wr_addr_i = '0;
    bus.wr_data_i = '0;
    test_reset();
    test_single();
    test_gap_burst();
    test_zero_len();
    test_abort();
    test_live_write();
    test_random();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
